pid_cfg_loader: RTL and testbench



---
 rtl/pid_cfg_pkg.sv | 27 ++
 rtl/pid_cfg_timeout.sv | 29 ++
 rtl/pid_cfg_loader.sv | 136 +++++++++++++
 tb/tb_pid_cfg_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_cfg_pkg.sv
// Shared types and frame layout for the PID/PWM configuration loader.
// Defining PID_CFG_CHECKSUM_EN adds a trailing XOR checksum word to every frame.
package pid_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int IDX_KP     = 0;
    localparam int IDX_KI     = 1;
    localparam int IDX_KD     = 2;
    localparam int IDX_SP     = 3;
    localparam int IDX_PERIOD = 4;

    localparam int PAYLOAD_WORDS = 5;
`ifdef PID_CFG_CHECKSUM_EN
    localparam int FRAME_WORDS = PAYLOAD_WORDS + 2;
`else
    localparam int FRAME_WORDS = PAYLOAD_WORDS + 1;
`endif
    // Every word after the header lands in the shadow, checksum included.
    localparam int SHADOW_WORDS = FRAME_WORDS - 1;

endpackage

// File: rtl/pid_cfg_timeout.sv
// Inter-word watchdog: counts enabled cycles and flags expiry on the last one.
module pid_cfg_timeout #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    assign expire = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pid_cfg_loader.sv
// Framed valid/ready loader that validates and atomically commits PID/PWM settings.
// Build option PID_CFG_CHECKSUM_EN enables the trailing XOR checksum word.
module pid_cfg_loader
    import pid_cfg_pkg::*;
#(
    parameter logic [31:0] MAGIC          = 32'hC0F1_9D00,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] PERIOD_MIN     = 32'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] kp,
    output logic [31:0] ki,
    output logic [31:0] kd,
    output logic [31:0] sp,
    output logic [31:0] period,
    output logic        cfg_update,
    output logic        cfg_loaded,
    output logic        frame_err
);

    localparam logic [2:0] IDX_LAST = 3'(SHADOW_WORDS - 1);

    state_t      state, state_next;
    logic [2:0]  idx;
    logic [31:0] shadow [SHADOW_WORDS];
    logic        xfer, start, store, reject, commit, expire, cksum_bad;

    assign in_ready = (state == IDLE) || (state == RECV);
    assign xfer     = in_valid && in_ready;

`ifdef PID_CFG_CHECKSUM_EN
    logic [31:0] xor_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_acc <= '0;
        end else if (start) begin
            xor_acc <= '0;
        end else if (store && (idx < 3'(PAYLOAD_WORDS))) begin
            xor_acc <= xor_acc ^ in_data;
        end
    end

    assign cksum_bad = (xor_acc != shadow[SHADOW_WORDS-1]);
`else
    assign cksum_bad = 1'b0;
`endif

    pid_cfg_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state != RECV) || xfer),
        .enable ((state == RECV) && !xfer),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        store      = 1'b0;
        reject     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (xfer && (in_data == MAGIC)) begin
                    start      = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                // A word arriving on the expiry cycle still counts as in time.
                if (xfer) begin
                    store = 1'b1;
                    if (idx == IDX_LAST) state_next = CHECK;
                end else if (expire) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                if ((shadow[IDX_PERIOD] < PERIOD_MIN) || cksum_bad) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            for (int i = 0; i < SHADOW_WORDS; i++) shadow[i] <= '0;
            kp         <= '0;
            ki         <= '0;
            kd         <= '0;
            sp         <= '0;
            period     <= '0;
            cfg_update <= 1'b0;
            cfg_loaded <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cfg_update <= commit;
            frame_err  <= reject;
            if (start) idx <= '0;
            if (store) begin
                shadow[idx] <= in_data;
                idx         <= idx + 3'd1;
            end
            if (commit) begin
                kp         <= shadow[IDX_KP];
                ki         <= shadow[IDX_KI];
                kd         <= shadow[IDX_KD];
                sp         <= shadow[IDX_SP];
                period     <= shadow[IDX_PERIOD];
                cfg_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pid_cfg_loader.sv
// Directed-plus-random bench for pid_cfg_loader with a frame-level reference model.
// Covers the checksum frames too when compiled with PID_CFG_CHECKSUM_EN.
module tb_pid_cfg_loader;

    localparam logic [31:0] MAGIC      = 32'hC0F1_9D00;
    localparam int          TIMEOUT    = 1024;
    localparam logic [31:0] PERIOD_MIN = 32'd2;

    logic        clk, rst, in_valid, in_ready;
    logic [31:0] in_data, kp, ki, kd, sp, period;
    logic        cfg_update, cfg_loaded, frame_err;

    pid_cfg_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .kp         (kp),
        .ki         (ki),
        .kd         (kd),
        .sp         (sp),
        .period     (period),
        .cfg_update (cfg_update),
        .cfg_loaded (cfg_loaded),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           vectors = 0;
    int           miscompares = 0;
    int           upd_cnt = 0, err_cnt = 0, exp_upd = 0, exp_err = 0;
    logic [159:0] exp_q[$];
    logic [159:0] mon_exp;
    logic [31:0]  m_kp, m_ki, m_kd, m_sp, m_period;
    logic         m_loaded;
    logic [31:0]  fr [5];

    // Every commit must match the oldest frame the model accepted.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (cfg_update === 1'b1) begin
            upd_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_commit: observed kp %h period %h, expected no commit", kp, period);
            end else begin
                mon_exp = exp_q.pop_front();
                assert ({kp, ki, kd, sp, period} === mon_exp) else begin
                    miscompares++;
                    $error("FAIL commit_values: observed %h expected %h", {kp, ki, kd, sp, period}, mon_exp);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_kp"}, kp, m_kp);
        check({tag, "_ki"}, ki, m_ki);
        check({tag, "_kd"}, kd, m_kd);
        check({tag, "_sp"}, sp, m_sp);
        check({tag, "_period"}, period, m_period);
        check({tag, "_loaded"}, {31'd0, cfg_loaded}, {31'd0, m_loaded});
        check({tag, "_updates"}, 32'(upd_cnt), 32'(exp_upd));
        check({tag, "_errors"}, 32'(err_cnt), 32'(exp_err));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one word and returns after the edge that accepts it.
    task automatic push_word(input logic [31:0] w, output int stalls);
        logic r;
        in_data  = w;
        in_valid = 1'b1;
        stalls   = 0;
        while (1) begin
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            stalls++;
            if (stalls > 20) begin
                vectors++;
                miscompares++;
                $error("FAIL push_timeout: observed in_ready low for %0d cycles, expected acceptance", stalls);
                break;
            end
        end
    endtask

    task automatic send_frame(input bit corrupt, input bit hold, input bit gaps, output int hdr_stalls);
        int          s;
        logic [31:0] x;
        x = '0;
        push_word(MAGIC, hdr_stalls);
        for (int i = 0; i < 5; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            push_word(fr[i], s);
            x ^= fr[i];
        end
`ifdef PID_CFG_CHECKSUM_EN
        push_word(x ^ {31'd0, corrupt}, s);
`endif
        if ((fr[4] >= PERIOD_MIN) && !corrupt) begin
            exp_q.push_back({fr[0], fr[1], fr[2], fr[3], fr[4]});
            m_kp = fr[0]; m_ki = fr[1]; m_kd = fr[2]; m_sp = fr[3]; m_period = fr[4];
            m_loaded = 1'b1;
            exp_upd++;
        end else begin
            exp_err++;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic random_frame(input bit want_valid);
        for (int i = 0; i < 4; i++) fr[i] = $urandom;
        if (want_valid) fr[4] = $urandom_range(2, 60000);
        else if ($urandom_range(0, 1) == 1) fr[4] = $urandom_range(0, 3);
        else fr[4] = $urandom;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int          s;
        logic [31:0] g;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        m_kp = '0; m_ki = '0; m_kd = '0; m_sp = '0; m_period = '0; m_loaded = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_update", {31'd0, cfg_update}, 32'd0);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        idle(2);

        // Basic frame with exact commit latency.
        fr = '{32'd1, 32'd2, 32'd3, 32'd100, 32'd1000};
        send_frame(1'b0, 1'b0, 1'b0, s);
        check("lat0_update", {31'd0, cfg_update}, 32'd0);
        check("lat0_ready", {31'd0, in_ready}, 32'd0);
        check("lat0_kp_old", kp, 32'd0);
        @(posedge clk); #1;
        check("lat1_update", {31'd0, cfg_update}, 32'd0);
        check("lat1_ready", {31'd0, in_ready}, 32'd0);
        check("lat1_period_old", period, 32'd0);
        @(posedge clk); #1;
        check("lat2_update", {31'd0, cfg_update}, 32'd1);
        check("lat2_period", period, 32'd1000);
        check("lat2_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("lat3_update", {31'd0, cfg_update}, 32'd0);
        check_outputs("frame1");

        // Garbage words in IDLE are dropped silently.
        push_word(32'h1234_5678, s);
        push_word(32'hDEAD_BEEF, s);
        idle(4);
        check_outputs("garbage");
        random_frame(1'b1);
        send_frame(1'b0, 1'b0, 1'b0, s);
        settle();
        check_outputs("after_garbage");

        // Inter-word timeout.
        push_word(MAGIC, s);
        push_word(32'd5, s);
        push_word(32'd6, s);
        idle(TIMEOUT - 1);
        check("timeout_early", {31'd0, frame_err}, 32'd0);
        @(posedge clk); #1;
        check("timeout_err", {31'd0, frame_err}, 32'd1);
        check("timeout_ready", {31'd0, in_ready}, 32'd1);
        exp_err++;
        settle();
        check_outputs("timeout");
        random_frame(1'b1);
        send_frame(1'b0, 1'b0, 1'b0, s);
        settle();
        check_outputs("after_timeout");

        // Period bounds: 1 and 0 reject, 2 is the smallest accepted.
        fr = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1};
        send_frame(1'b0, 1'b0, 1'b0, s);
        settle();
        check_outputs("period_1");
        fr = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd0};
        send_frame(1'b0, 1'b0, 1'b0, s);
        settle();
        check_outputs("period_0");
        fr = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd2};
        send_frame(1'b0, 1'b0, 1'b0, s);
        settle();
        check_outputs("period_2");

        // Randomized frames with gaps and interleaved garbage.
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                g = $urandom;
                if (g == MAGIC) g = g ^ 32'd1;
                push_word(g, s);
            end
            random_frame($urandom_range(0, 2) != 0);
            send_frame(1'b0, 1'b0, 1'b1, s);
            settle();
            check_outputs("random");
        end

        // Back-to-back frames with in_valid held high.
        random_frame(1'b1);
        send_frame(1'b0, 1'b1, 1'b0, s);
        random_frame(1'b1);
        send_frame(1'b0, 1'b0, 1'b0, s);
        check("b2b_stalls", 32'(s), 32'd2);
        settle();
        check_outputs("b2b");

`ifdef PID_CFG_CHECKSUM_EN
        fr = '{32'd1, 32'd2, 32'd3, 32'd100, 32'd1000};
        send_frame(1'b0, 1'b0, 1'b0, s);
        settle();
        check_outputs("cksum_good");
        send_frame(1'b1, 1'b0, 1'b0, s);
        settle();
        check_outputs("cksum_bad");
`endif

        // Reset in the middle of a frame.
        push_word(MAGIC, s);
        for (int i = 0; i < 3; i++) push_word($urandom, s);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_kp = '0; m_ki = '0; m_kd = '0; m_sp = '0; m_period = '0; m_loaded = 1'b0;
        check_outputs("midreset");
        check("midreset_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        random_frame(1'b1);
        send_frame(1'b0, 1'b0, 1'b0, s);
        settle();
        check_outputs("after_reset");

        check("pending_commits", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
